// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the switch debouncer:
//   state_e             - 2-bit FSM state encoding (Gray-ordered around the loop
//                         LOW -> CHK_HIGH -> HIGH -> CHK_LOW, one bit per step)
//   STABLE_CYCLES_DEF   - default qualification length in synchronized cycles
// No ports (package).
// -----------------------------------------------------------------------------
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW      = 2'b00,
    S_CHK_HIGH = 2'b01,
    S_HIGH     = 2'b11,
    S_CHK_LOW  = 2'b10
  } state_e;

  localparam int unsigned STABLE_CYCLES_DEF = 32'd4;

endpackage : debounce_pkg

// File: rtl/switch_debouncer_sync.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Ports:
//   clk - sampling clock (rising edge)
//   rst - asynchronous active-low reset, clears both flops
//   d   - asynchronous input level
//   q   - synchronized level, two clk edges after d settles
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  // Two-stage capture; the first flop may go metastable, the second settles it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule : sync_2ff

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Debounces a bouncing mechanical switch. raw_in is synchronized, and a new
// level is accepted only after it holds for STABLE_CYCLES+1 consecutive
// synchronized samples (one sample to enter the check state, STABLE_CYCLES
// counted while checking). Any reversal while checking aborts with no pulse.
// Ports:
//   clk    - single clock, rising edge
//   rst    - asynchronous active-low reset
//   raw_in - raw switch level (asynchronous, may bounce)
//   D      - debounced level (registered)
//   rise   - one-cycle pulse when D goes 0->1 (registered)
//   fall   - one-cycle pulse when D goes 1->0 (registered)
//   busy   - high while a candidate level change is being qualified (registered)
// -----------------------------------------------------------------------------
module switch_debouncer
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic D,
  output logic rise,
  output logic fall,
  output logic busy
);

  localparam int unsigned       CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 32'd1);

  logic             sync_s;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             d_q, d_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (raw_in),
    .q   (sync_s)
  );

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      S_LOW: begin
        if (sync_s) begin
          state_d = S_CHK_HIGH;
          cnt_d   = '0;
        end else begin
          state_d = S_LOW;
        end
      end
      S_CHK_HIGH: begin
        if (!sync_s) begin
          state_d = S_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_HIGH;
          cnt_d   = '0;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_HIGH: begin
        if (!sync_s) begin
          state_d = S_CHK_LOW;
          cnt_d   = '0;
        end else begin
          state_d = S_HIGH;
        end
      end
      S_CHK_LOW: begin
        if (sync_s) begin
          state_d = S_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase
    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    d_d    = (state_d == S_HIGH)     || (state_d == S_CHK_LOW);
    busy_d = (state_d == S_CHK_HIGH) || (state_d == S_CHK_LOW);
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      d_q     <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign D    = d_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign busy = busy_q;

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// -----------------------------------------------------------------------------
// tb_switch_debouncer
// Self-checking bench for switch_debouncer (STABLE_CYCLES=4, 20 ns clock).
// Reference model: raw_in is delayed two edges, and D flips once the delayed
// level has differed from D on STABLE_CYCLES+1 consecutive edges; any sample
// equal to D resets that run. busy is "a run is in progress".
// -----------------------------------------------------------------------------
module tb_switch_debouncer;

  localparam int unsigned SC  = 32'd4;
  localparam int          LAT = 7;  // edges from a settled step to D changing

  logic clk = 1'b0;
  logic rst;
  logic raw_in;
  logic D, rise, fall, busy;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic m_s1, m_s2, m_d, m_rise, m_fall, m_busy;
  int   m_run;

  switch_debouncer #(.STABLE_CYCLES(SC)) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .D      (D),
    .rise   (rise),
    .fall   (fall),
    .busy   (busy)
  );

  always #10 clk = ~clk;

  function automatic void model_reset();
    m_s1 = 1'b0; m_s2 = 1'b0; m_d = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_busy = 1'b0; m_run = 0;
  endfunction

  // Drive raw_in, advance one rising edge, update the model, settle 1 ns.
  task automatic tick(input logic r);
    logic seen;
    raw_in = r;
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      seen   = m_s2;
      m_s2   = m_s1;
      m_s1   = r;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (seen != m_d) begin
        m_run++;
        if (m_run == int'(SC) + 1) begin
          m_d    = seen;
          m_rise = seen;
          m_fall = ~seen;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
      m_busy = (m_run > 0);
    end
    #1;
  endtask

  task automatic test_reset();
    int lat;
    int rises;
    rst = 1'b0; raw_in = 1'b1;
    model_reset();
    for (int i = 0; i < 9; i++) begin
      #1;
      checks++;
      if ({D, rise, fall, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hold t=%0t D/rise/fall/busy=%b want 0000", $time, {D, rise, fall, busy});
      end
      #9;
    end
    @(posedge clk); #1;
    rst = 1'b1;
    lat = 0; rises = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1);
      checks++;
      if ({D, rise, fall, busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL reset_release edge %0d got %b want %b", i, {D, rise, fall, busy}, {m_d, m_rise, m_fall, m_busy});
      end
      if (D === 1'b1 && lat == 0) lat = i;
      if (rise === 1'b1) rises++;
    end
    checks++;
    if (lat != LAT || rises != 1) begin
      errors++;
      $display("FAIL reset_release_latency got edge %0d rises %0d want edge %0d rises 1", lat, rises, LAT);
    end
  endtask

  task automatic test_falling_edge();
    int lat;
    int rises;
    lat = 0; rises = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b0);
      checks++;
      if ({D, rise, fall, busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL falling_edge edge %0d got %b want %b", i, {D, rise, fall, busy}, {m_d, m_rise, m_fall, m_busy});
      end
      if (fall === 1'b1 && lat == 0) lat = i;
      if (rise === 1'b1) rises++;
    end
    checks++;
    if (lat != LAT || rises != 0 || D !== 1'b0) begin
      errors++;
      $display("FAIL falling_edge_latency fall at edge %0d rises %0d D %b want edge %0d rises 0 D 0", lat, rises, D, LAT);
    end
  endtask

  task automatic test_clean_step();
    int lat;
    int busy_cnt;
    lat = 0; busy_cnt = 0;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1);
      checks++;
      if ({D, rise, fall, busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL clean_step edge %0d got %b want %b", i, {D, rise, fall, busy}, {m_d, m_rise, m_fall, m_busy});
      end
      if (rise === 1'b1 && lat == 0) lat = i;
      if (busy === 1'b1) busy_cnt++;
    end
    checks++;
    if (lat != LAT || busy_cnt != int'(SC)) begin
      errors++;
      $display("FAIL clean_step_timing rise at edge %0d busy cycles %0d want %0d and %0d", lat, busy_cnt, LAT, SC);
    end
    for (int i = 0; i < 10; i++) tick(1'b0);
  endtask

  task automatic test_bounce_reject();
    int rises;
    rises = 0;
    for (int i = 0; i < 12; i++) begin
      tick((i < 2) ? 1'b1 : 1'b0);
      checks++;
      if ({D, rise, fall, busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL bounce_reject cyc %0d got %b want %b", i, {D, rise, fall, busy}, {m_d, m_rise, m_fall, m_busy});
      end
      if (rise === 1'b1 || D === 1'b1) rises++;
    end
    checks++;
    if (rises != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bounce_reject_final D/rise seen %0d busy %b want 0 and 0", rises, busy);
    end
  endtask

  task automatic test_bounce_train();
    int rises;
    int lat;
    rises = 0; lat = 0;
    for (int i = 0; i < 10; i++) begin
      tick((i % 2 == 0) ? 1'b1 : 1'b0);
      checks++;
      if ({D, rise, fall, busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL bounce_train toggle %0d got %b want %b", i, {D, rise, fall, busy}, {m_d, m_rise, m_fall, m_busy});
      end
      if (rise === 1'b1) rises++;
    end
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1);
      checks++;
      if ({D, rise, fall, busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL bounce_train hold %0d got %b want %b", i, {D, rise, fall, busy}, {m_d, m_rise, m_fall, m_busy});
      end
      if (rise === 1'b1) rises++;
      if (D === 1'b1 && lat == 0) lat = i;
    end
    checks++;
    if (rises != 1 || lat != LAT) begin
      errors++;
      $display("FAIL bounce_train_result rises %0d D at edge %0d want 1 and %0d", rises, lat, LAT);
    end
  endtask

  task automatic test_reset_mid_qual();
    int lat;
    int pulses;
    for (int i = 0; i < 10; i++) tick(1'b0);
    for (int i = 0; i < 4; i++) tick(1'b1);
    #4;
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({D, rise, fall, busy, dut.cnt_q} !== {4'b0000, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_qual_async got D/rise/fall/busy/cnt=%b want 000000", {D, rise, fall, busy, dut.cnt_q});
    end
    lat = 0; pulses = 0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b1);
      checks++;
      if ({D, rise, fall, busy} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_mid_qual_hold cyc %0d got %b want 0000", i, {D, rise, fall, busy});
      end
    end
    rst = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick(1'b1);
      checks++;
      if ({D, rise, fall, busy} !== {m_d, m_rise, m_fall, m_busy}) begin
        errors++;
        $display("FAIL reset_mid_qual_requal edge %0d got %b want %b", i, {D, rise, fall, busy}, {m_d, m_rise, m_fall, m_busy});
      end
      if (D === 1'b1 && lat == 0) lat = i;
      if (rise === 1'b1 || fall === 1'b1) pulses++;
    end
    checks++;
    if (lat != LAT || pulses != 1) begin
      errors++;
      $display("FAIL reset_mid_qual_latency D at edge %0d pulses %0d want %0d and 1", lat, pulses, LAT);
    end
  endtask

  task automatic test_random();
    logic r;
    int   hold;
    r = 1'b0;
    for (int n = 0; n < 80; n++) begin
      r    = ~r;
      hold = int'($urandom_range(8, 1));
      for (int h = 0; h < hold; h++) begin
        tick(r);
        checks++;
        if ({D, rise, fall, busy} !== {m_d, m_rise, m_fall, m_busy} || (rise === 1'b1 && fall === 1'b1)) begin
          errors++;
          $display("FAIL random seg %0d got %b want %b", n, {D, rise, fall, busy}, {m_d, m_rise, m_fall, m_busy});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_falling_edge();
    test_clean_step();
    test_bounce_reject();
    test_bounce_train();
    test_reset_mid_qual();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_switch_debouncer
